// File: rtl/aux_panel_controller.sv
// Next-piece queue, hold slot and preview-box pixel renderer for the game.
// Spawn/hold requests are served through a two-state IDLE/ISSUE handshake.
module aux_panel_controller #(
    parameter int         SWAP_X0   = 140,
    parameter int         NEXT_X0   = 540,
    parameter int         BOX_Y0    = 100,
    parameter int         CELL      = 20,
    parameter logic [6:0] LFSR_SEED = 7'h01
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    input  logic       is_swap_grid,
    input  logic       is_next_grid,
    input  logic       spawn_req,
    input  logic       swap_req,
    input  logic       piece_locked,
    output logic       spawn_valid,
    output logic [2:0] spawn_piece,
    output logic       swap_done,
    output logic [2:0] next_piece,
    output logic [2:0] hold_piece,
    output logic       busy,
    output logic [3:0] aux_color
);

    typedef enum logic {IDLE, ISSUE} state_t;

    localparam logic [2:0] NONE    = 3'd7;
    localparam logic [9:0] SWAP_LO = 10'(SWAP_X0);
    localparam logic [9:0] SWAP_HI = 10'(SWAP_X0 + 4 * CELL);
    localparam logic [9:0] NEXT_LO = 10'(NEXT_X0);
    localparam logic [9:0] NEXT_HI = 10'(NEXT_X0 + 4 * CELL);
    localparam logic [9:0] ROW_LO  = 10'(BOX_Y0);
    localparam logic [9:0] ROW_HI  = 10'(BOX_Y0 + 3 * CELL);
    localparam logic [9:0] CELL_W  = 10'(CELL);

    state_t     state;
    logic [6:0] lfsr;
    logic [2:0] active;
    logic       swap_lock;
    logic [2:0] refill;

    // Occupancy of a preview row; row 1 holds mask A, row 2 mask B, bit 3 = column 0.
    function automatic logic [3:0] row_mask(input logic [2:0] piece, input logic [1:0] row);
        logic [3:0] mask_a;
        logic [3:0] mask_b;
        case (piece)
            3'd0:    begin mask_a = 4'b0000; mask_b = 4'b1111; end
            3'd1:    begin mask_a = 4'b0110; mask_b = 4'b0110; end
            3'd2:    begin mask_a = 4'b0100; mask_b = 4'b1110; end
            3'd3:    begin mask_a = 4'b0110; mask_b = 4'b1100; end
            3'd4:    begin mask_a = 4'b1100; mask_b = 4'b0110; end
            3'd5:    begin mask_a = 4'b1000; mask_b = 4'b1110; end
            3'd6:    begin mask_a = 4'b0010; mask_b = 4'b1110; end
            default: begin mask_a = 4'b0000; mask_b = 4'b0000; end
        endcase
        case (row)
            2'd1:    return mask_a;
            2'd2:    return mask_b;
            default: return 4'b0000;
        endcase
    endfunction

    assign refill = 3'(lfsr % 7'd7);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= IDLE;
            lfsr        <= LFSR_SEED;
            next_piece  <= 3'd0;
            hold_piece  <= NONE;
            active      <= NONE;
            swap_lock   <= 1'b0;
            spawn_valid <= 1'b0;
            swap_done   <= 1'b0;
            spawn_piece <= 3'd0;
            busy        <= 1'b0;
        end else begin
            lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
            case (state)
                IDLE: begin
                    spawn_valid <= 1'b0;
                    swap_done   <= 1'b0;
                    busy        <= 1'b0;
                    if (piece_locked) begin
                        swap_lock <= 1'b0;
                        active    <= NONE;
                    end else if (spawn_req) begin
                        spawn_piece <= next_piece;
                        active      <= next_piece;
                        next_piece  <= refill;
                        spawn_valid <= 1'b1;
                        busy        <= 1'b1;
                        state       <= ISSUE;
                    end else if (swap_req && !swap_lock && active != NONE) begin
                        hold_piece  <= active;
                        swap_lock   <= 1'b1;
                        swap_done   <= 1'b1;
                        spawn_valid <= 1'b1;
                        busy        <= 1'b1;
                        state       <= ISSUE;
                        // An empty hold slot pulls the replacement from the next queue.
                        if (hold_piece == NONE) begin
                            spawn_piece <= next_piece;
                            active      <= next_piece;
                            next_piece  <= refill;
                        end else begin
                            spawn_piece <= hold_piece;
                            active      <= hold_piece;
                        end
                    end
                end
                ISSUE: begin
                    spawn_valid <= 1'b0;
                    swap_done   <= 1'b0;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic       in_rows;
    logic       in_box;
    logic [2:0] box_piece;
    logic [1:0] box_col;
    logic [1:0] box_row;
    logic [3:0] mask;
    logic [3:0] color_p0;

    always_comb begin
        in_rows   = (DrawY >= ROW_LO) && (DrawY < ROW_HI);
        in_box    = 1'b0;
        box_piece = NONE;
        box_col   = 2'd0;
        box_row   = 2'(( DrawY - ROW_LO) / CELL_W);
        if (in_rows && DrawX >= SWAP_LO && DrawX < SWAP_HI) begin
            in_box    = 1'b1;
            box_piece = hold_piece;
            box_col   = 2'((DrawX - SWAP_LO) / CELL_W);
        end else if (in_rows && DrawX >= NEXT_LO && DrawX < NEXT_HI) begin
            in_box    = 1'b1;
            box_piece = next_piece;
            box_col   = 2'((DrawX - NEXT_LO) / CELL_W);
        end
        mask     = row_mask(box_piece, box_row);
        color_p0 = 4'd0;
        if (is_swap_grid || is_next_grid)
            color_p0 = 4'd8;
        else if (in_box && box_piece != NONE && mask[2'd3 - box_col])
            color_p0 = {1'b0, box_piece} + 4'd1;
    end

    // Pixel stage p0 -> registered colour index
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            aux_color <= 4'd0;
        else
            aux_color <= color_p0;
    end

endmodule

// File: tb/tb_aux_panel_controller.sv
// Directed bench for aux_panel_controller: queue/hold handshake and preview pixels.
module tb_aux_panel_controller;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic [9:0] DrawX = 10'd0;
    logic [9:0] DrawY = 10'd0;
    logic       is_swap_grid = 1'b0;
    logic       is_next_grid = 1'b0;
    logic       spawn_req = 1'b0;
    logic       swap_req = 1'b0;
    logic       piece_locked = 1'b0;
    logic       spawn_valid;
    logic [2:0] spawn_piece;
    logic       swap_done;
    logic [2:0] next_piece;
    logic [2:0] hold_piece;
    logic       busy;
    logic [3:0] aux_color;

    aux_panel_controller dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .DrawX        (DrawX),
        .DrawY        (DrawY),
        .is_swap_grid (is_swap_grid),
        .is_next_grid (is_next_grid),
        .spawn_req    (spawn_req),
        .swap_req     (swap_req),
        .piece_locked (piece_locked),
        .spawn_valid  (spawn_valid),
        .spawn_piece  (spawn_piece),
        .swap_done    (swap_done),
        .next_piece   (next_piece),
        .hold_piece   (hold_piece),
        .busy         (busy),
        .aux_color    (aux_color)
    );

    always #5 Clk = ~Clk;

    // Reference LFSR stepping alongside the DUT's.
    logic [6:0] lfsr_m;
    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) lfsr_m <= 7'h01;
        else          lfsr_m <= {lfsr_m[5:0], lfsr_m[6] ^ lfsr_m[5]};
    end

    int vectors = 0;
    int miscompares = 0;
    logic [2:0] exp_next;
    logic [2:0] exp_hold;
    logic [2:0] exp_spawn;
    logic [2:0] pred;
    logic [2:0] saved;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic req(input logic s, input logic w, input logic l);
        spawn_req = s;
        swap_req = w;
        piece_locked = l;
        tick();
        spawn_req = 1'b0;
        swap_req = 1'b0;
        piece_locked = 1'b0;
    endtask

    task automatic do_spawn();
        exp_spawn = exp_next;
        pred = 3'(lfsr_m % 7'd7);
        req(1'b1, 1'b0, 1'b0);
        check("spawn_valid", 8'(spawn_valid), 8'd1);
        check("spawn_piece", 8'(spawn_piece), 8'(exp_spawn));
        check("spawn_busy", 8'(busy), 8'd1);
        check("spawn_swap_done", 8'(swap_done), 8'd0);
        check("spawn_next", 8'(next_piece), 8'(pred));
        exp_next = pred;
        tick();
        check("spawn_valid_drop", 8'(spawn_valid), 8'd0);
        check("spawn_busy_drop", 8'(busy), 8'd0);
    endtask

    task automatic pix(input string tag, input int x, input int y, input logic sg,
                       input logic ng, input logic [3:0] exp);
        DrawX = 10'(x);
        DrawY = 10'(y);
        is_swap_grid = sg;
        is_next_grid = ng;
        tick();
        check(tag, 8'(aux_color), 8'(exp));
    endtask

    initial begin
        exp_next = 3'd0;
        exp_hold = 3'd7;
        tick();
        tick();
        check("rst_spawn_valid", 8'(spawn_valid), 8'd0);
        check("rst_busy", 8'(busy), 8'd0);
        check("rst_swap_done", 8'(swap_done), 8'd0);
        check("rst_spawn_piece", 8'(spawn_piece), 8'd0);
        check("rst_next", 8'(next_piece), 8'd0);
        check("rst_hold", 8'(hold_piece), 8'd7);
        check("rst_color", 8'(aux_color), 8'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        tick();

        // Empty hold box draws nothing; next box shows I in its bottom row.
        pix("pix_hold_empty", 150, 145, 1'b0, 1'b0, 4'd0);
        pix("pix_next_I_row2", 545, 145, 1'b0, 1'b0, 4'd1);
        pix("pix_next_I_row1", 545, 125, 1'b0, 1'b0, 4'd0);
        pix("pix_outside_grid", 300, 145, 1'b0, 1'b1, 4'd8);
        pix("pix_outside", 300, 145, 1'b0, 1'b0, 4'd0);

        // Swap with no active piece is ignored.
        req(1'b0, 1'b1, 1'b0);
        check("swap_no_active", 8'(spawn_valid), 8'd0);
        tick();

        do_spawn();
        for (int i = 0; i < 130 && exp_next != 3'd2; i++) do_spawn();
        check("reach_T_in_queue", 8'(exp_next), 8'd2);
        do_spawn();

        // Active T, hold empty: swap pulls from the queue.
        exp_spawn = exp_next;
        pred = 3'(lfsr_m % 7'd7);
        req(1'b0, 1'b1, 1'b0);
        check("swapE_valid", 8'(spawn_valid), 8'd1);
        check("swapE_done", 8'(swap_done), 8'd1);
        check("swapE_piece", 8'(spawn_piece), 8'(exp_spawn));
        check("swapE_hold", 8'(hold_piece), 8'd2);
        check("swapE_next", 8'(next_piece), 8'(pred));
        exp_next = pred;
        exp_hold = 3'd2;
        tick();
        check("swapE_done_drop", 8'(swap_done), 8'd0);

        req(1'b0, 1'b1, 1'b0);
        check("swap_locked_valid", 8'(spawn_valid), 8'd0);
        check("swap_locked_hold", 8'(hold_piece), 8'(exp_hold));
        tick();

        req(1'b0, 1'b0, 1'b1);
        check("lock_no_valid", 8'(spawn_valid), 8'd0);
        req(1'b0, 1'b1, 1'b0);
        check("swap_after_lock_noactive", 8'(spawn_valid), 8'd0);
        tick();

        // New active piece, hold occupied: swap exchanges, queue untouched.
        saved = exp_next;
        do_spawn();
        req(1'b0, 1'b1, 1'b0);
        check("swapH_valid", 8'(spawn_valid), 8'd1);
        check("swapH_done", 8'(swap_done), 8'd1);
        check("swapH_piece", 8'(spawn_piece), 8'(exp_hold));
        check("swapH_hold", 8'(hold_piece), 8'(saved));
        check("swapH_next", 8'(next_piece), 8'(exp_next));
        exp_hold = saved;
        tick();

        // All three requests at once: only piece_locked acts.
        req(1'b1, 1'b1, 1'b1);
        check("tri_no_valid", 8'(spawn_valid), 8'd0);
        check("tri_busy", 8'(busy), 8'd0);
        check("tri_next", 8'(next_piece), 8'(exp_next));
        check("tri_hold", 8'(hold_piece), 8'(exp_hold));
        req(1'b0, 1'b1, 1'b0);
        check("tri_active_cleared", 8'(spawn_valid), 8'd0);
        tick();

        // Fresh reset, then put I in the hold box.
        Reset_n = 1'b0;
        tick();
        @(negedge Clk);
        Reset_n = 1'b1;
        tick();
        exp_next = 3'd0;
        do_spawn();
        exp_spawn = exp_next;
        req(1'b0, 1'b1, 1'b0);
        check("holdI_piece", 8'(spawn_piece), 8'(exp_spawn));
        check("holdI_hold", 8'(hold_piece), 8'd0);
        tick();

        pix("pix_I_row2", 150, 145, 1'b0, 1'b0, 4'd1);
        pix("pix_I_row1", 150, 125, 1'b0, 1'b0, 4'd0);
        pix("pix_I_grid", 160, 145, 1'b1, 1'b0, 4'd8);
        pix("pix_I_col3", 219, 159, 1'b0, 1'b0, 4'd1);
        pix("pix_I_xedge", 220, 145, 1'b0, 1'b0, 4'd0);
        pix("pix_I_yedge", 150, 160, 1'b0, 1'b0, 4'd0);

        // Reset arriving while ISSUE is in progress.
        DrawX = 10'd160;
        DrawY = 10'd145;
        is_swap_grid = 1'b1;
        req(1'b1, 1'b0, 1'b0);
        check("pre_rst_valid", 8'(spawn_valid), 8'd1);
        check("pre_rst_color", 8'(aux_color), 8'd8);
        Reset_n = 1'b0;
        #1;
        check("midrst_valid", 8'(spawn_valid), 8'd0);
        check("midrst_busy", 8'(busy), 8'd0);
        check("midrst_color", 8'(aux_color), 8'd0);
        check("midrst_hold", 8'(hold_piece), 8'd7);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/aux_panel_controller.md
Name: aux_panel_controller

Overview:
- Owns the next-piece queue and the hold (swap) slot for the game.
- Serves piece-spawn and hold-swap requests from the game FSM over a one-cycle handshake.
- Renders the contents of the next and swap preview boxes as a registered colour index for the VGA colour mapper.
- Consumes DrawX/DrawY and the is_swap_grid / is_next_grid grid-line flags from the preview-box grid mappers.

Parameters:
- SWAP_X0, 140, left pixel edge of the swap box.
- NEXT_X0, 540, left pixel edge of the next box.
- BOX_Y0, 100, top pixel edge of both boxes.
- CELL, 20, cell size in pixels.
- LFSR_SEED, 7'h01, LFSR value loaded on reset.

Ports:
- Clk  in  1  system clock (pixel clock domain).
- Reset_n  in  1  asynchronous active-low reset.
- DrawX  in  10  current pixel x.
- DrawY  in  10  current pixel y.
- is_swap_grid  in  1  swap-box grid-line flag for (DrawX, DrawY).
- is_next_grid  in  1  next-box grid-line flag for (DrawX, DrawY).
- spawn_req  in  1  one-cycle pulse: game needs a new active piece.
- swap_req  in  1  one-cycle pulse: player pressed hold.
- piece_locked  in  1  one-cycle pulse: active piece landed.
- spawn_valid  out  1  one-cycle pulse: spawn_piece is valid.
- spawn_piece  out  3  piece code for the new active piece.
- swap_done  out  1  pulse alongside spawn_valid when the spawn came from a swap.
- next_piece  out  3  current next-queue piece.
- hold_piece  out  3  current hold piece; 7 = empty.
- busy  out  1  high while in ISSUE.
- aux_color  out  4  colour index for the current pixel.

Behaviour:
- Piece codes: I=0, O=1, T=2, S=3, Z=4, J=5, L=6; 7 = none.
- Reset (async, Reset_n=0) loads:
  - lfsr = LFSR_SEED, next_piece = 0, hold_piece = 7, active = 7, swap_lock = 0.
  - spawn_valid = 0, swap_done = 0, spawn_piece = 0, busy = 0, aux_color = 0, state = IDLE.
- LFSR: 7-bit; each cycle lfsr <= {lfsr[5:0], lfsr[6]^lfsr[5]}. Refill value = lfsr mod 7 (0..6).
- FSM has two states, IDLE and ISSUE.
- IDLE, request priority is piece_locked > spawn_req > swap_req (only one accepted per cycle; the rest are dropped):
  - piece_locked: swap_lock <= 0, active <= 7. Stay in IDLE.
  - spawn_req: spawn_piece <= next_piece, active <= next_piece, next_piece <= refill. Go to ISSUE.
  - swap_req with swap_lock=0, active!=7 and hold=7: hold <= active; spawn_piece/active <= next_piece; next_piece <= refill; swap_lock <= 1; swap_done flag set. Go to ISSUE.
  - swap_req with swap_lock=0, active!=7 and hold!=7: spawn_piece/active <= hold; hold <= active; swap_lock <= 1; swap_done flag set; next_piece unchanged. Go to ISSUE.
  - swap_req with swap_lock=1 or active=7: ignored. No outputs change.
- ISSUE lasts exactly 1 cycle:
  - spawn_valid=1, busy=1; swap_done=1 if the swap flag is set.
  - All requests arriving in ISSUE are ignored.
  - Returns to IDLE.
- Latency: request at cycle N, spawn_valid at cycle N+1.
- Pixel path, one register stage (aux_color valid one Clk after DrawX/DrawY):
  - Box select: DrawX in [SWAP_X0, SWAP_X0+4*CELL) shows hold_piece; DrawX in [NEXT_X0, NEXT_X0+4*CELL) shows next_piece.
  - Row range for both boxes: DrawY in [BOX_Y0, BOX_Y0+3*CELL).
  - col = (DrawX-X0)/CELL (0..3); row = (DrawY-BOX_Y0)/CELL (0..2).
  - Piece occupies rows 1 (mask A) and 2 (mask B); bit 3 of each mask is column 0.
  - Masks A/B: I 0000/1111, O 0110/0110, T 0100/1110, S 0110/1100, Z 1100/0110, J 1000/1110, L 0010/1110.
  - Priority: is_swap_grid or is_next_grid → 8. Otherwise mask bit set and piece!=7 → piece+1. Otherwise 0.
  - Pixels outside both boxes → 0, unless a grid flag is set (then 8).
- Reset mid-operation: an ISSUE in progress is aborted; spawn_valid is 0 immediately.

Test Plan:
- Reset, then spawn_req at cycle 5 → spawn_valid and spawn_piece=0 at cycle 6 only; next_piece becomes lfsr mod 7; busy=1 for 1 cycle.
- After a spawn of T (2), hold empty, swap_req → spawn_piece=next, swap_done=1, hold_piece=2. A second swap_req is ignored until piece_locked.
- Hold=S (3), active=J (5), swap_lock=0, swap_req → spawn_piece=3, hold_piece=5, next_piece unchanged.
- spawn_req, swap_req and piece_locked in the same cycle → only piece_locked acts; no spawn_valid.
- hold_piece=I, DrawX=150, DrawY=145, grid flags 0 → aux_color=1 one cycle later.
- Same hold_piece=I, DrawY=125 → aux_color=0.
- DrawX=160, DrawY=145 with is_swap_grid=1 → aux_color=8.
- hold_piece=7, DrawX=150, DrawY=145 → aux_color=0.
- Reset_n asserted during ISSUE → spawn_valid, busy and aux_color are 0 in the same cycle; hold_piece=7.
